rom_fetch_sequencer: RTL and testbench

// - Drives the 12-bit address of the 4K x 8 program ROM (asynchronous read, data valid same cycle)
//   and fetches 1- or 2-byte instructions into an issue register.
// - Presents {opcode, operand, immediate} to the downstream decoder with a valid/ready handshake.
// - Sits between the program ROM and the nibble-datapath control unit; owns the program counter.

---
 rtl/rom_fetch_sequencer_pkg.sv | 22 ++
 rtl/rom_fetch_sequencer_program_counter.sv | 36 +++
 rtl/rom_fetch_sequencer.sv | 119 +++++++++++
 tb/tb_rom_fetch_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rom_fetch_sequencer_pkg.sv
// Shared definitions for the ROM fetch sequencer: default widths, long-instruction marker
// bit and the fetch FSM state encoding.
package rom_fetch_sequencer_pkg;

    localparam int unsigned DEF_ADDR_W   = 12;
    localparam int unsigned DEF_DATA_W   = 8;
    localparam int unsigned DEF_LONG_BIT = 3;
    localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = 12'h000;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH1 = 2'd1;
    localparam logic [1:0] S_FETCH2 = 2'd2;
    localparam logic [1:0] S_ISSUE  = 2'd3;

    typedef enum logic [1:0] {
        StIdle   = S_IDLE,
        StFetch1 = S_FETCH1,
        StFetch2 = S_FETCH2,
        StIssue  = S_ISSUE
    } state_e;

endpackage

// File: rtl/rom_fetch_sequencer_program_counter.sv
// Program counter: synchronous reset, jump load and increment, wrapping modulo 2^ADDR_W.
// Load has priority over increment.
module rom_fetch_sequencer_program_counter #(
    parameter int unsigned        ADDR_W   = 12,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_value,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_value;
        end else if (inc) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/rom_fetch_sequencer.sv
// Fetches 1- or 2-byte instructions from an asynchronous program ROM into an issue register
// and hands them to the decoder over a valid/ready handshake.
module rom_fetch_sequencer
    import rom_fetch_sequencer_pkg::*;
#(
    parameter int unsigned        ADDR_W   = DEF_ADDR_W,
    parameter int unsigned        DATA_W   = DEF_DATA_W,
    parameter int unsigned        LONG_BIT = DEF_LONG_BIT,
    parameter logic [ADDR_W-1:0]  RESET_PC = DEF_RESET_PC
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                load_pc,
    input  logic [ADDR_W-1:0]   load_addr,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [DATA_W-1:0]   rom_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W/2-1:0] opcode,
    output logic [DATA_W/2-1:0] operand,
    output logic [DATA_W-1:0]   imm,
    output logic                is_long,
    output logic [ADDR_W-1:0]   pc_out
);

    localparam int unsigned NIB_W = DATA_W / 2;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc;
    logic [DATA_W-1:0]   ir_q;
    logic [DATA_W-1:0]   imm_q;
    logic [ADDR_W-1:0]   pc_out_q;
    logic                capture_first;
    logic                capture_imm;
    logic                pc_inc;

    rom_fetch_sequencer_program_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .reset      (reset),
        .load       (load_pc),
        .load_value (load_addr),
        .inc        (pc_inc),
        .pc         (pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // A jump discards whatever is in flight or held, including an instruction being accepted.
    always_comb begin
        state_d = state_q;
        if (load_pc) begin
            state_d = enable ? StFetch1 : StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (enable) begin
                        state_d = StFetch1;
                    end
                end
                StFetch1: begin
                    state_d = rom_data[NIB_W + LONG_BIT] ? StFetch2 : StIssue;
                end
                StFetch2: begin
                    state_d = StIssue;
                end
                StIssue: begin
                    if (out_ready) begin
                        state_d = enable ? StFetch1 : StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_comb begin
        out_valid     = (state_q == StIssue);
        capture_first = (state_q == StFetch1) && !load_pc;
        capture_imm   = (state_q == StFetch2) && !load_pc;
        pc_inc        = capture_first || capture_imm;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q     <= '0;
            imm_q    <= '0;
            pc_out_q <= '0;
        end else begin
            if (capture_first) begin
                ir_q     <= rom_data;
                imm_q    <= '0;
                pc_out_q <= pc;
            end
            if (capture_imm) begin
                imm_q <= rom_data;
            end
        end
    end

    assign rom_addr = pc;
    assign opcode   = ir_q[DATA_W-1:NIB_W];
    assign operand  = ir_q[NIB_W-1:0];
    assign imm      = imm_q;
    assign is_long  = ir_q[NIB_W + LONG_BIT];
    assign pc_out   = pc_out_q;

endmodule

// File: tb/tb_rom_fetch_sequencer.sv
// Bench for rom_fetch_sequencer: directed vector table, a hand-written jump sequence and a
// randomized run checked against an instruction-level model of the program.
module tb_rom_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset, enable, load_pc, out_ready;
    logic [11:0] load_addr, rom_addr, pc_out;
    logic [7:0]  rom_data, imm;
    logic [3:0]  opcode, operand;
    logic        out_valid, is_long;

    logic [7:0]  rom [4096];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    rom_fetch_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .load_pc   (load_pc),
        .load_addr (load_addr),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .opcode    (opcode),
        .operand   (operand),
        .imm       (imm),
        .is_long   (is_long),
        .pc_out    (pc_out)
    );

    typedef struct {
        logic        rst;
        logic        en;
        logic        ld;
        logic [11:0] addr;
        logic        rdy;
        logic        v;
        logic [3:0]  op;
        logic [3:0]  opd;
        logic [7:0]  im;
        logic        lg;
        logic [11:0] pco;
        logic [11:0] ra;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic en, logic ld, logic [11:0] addr, logic rdy,
                                logic v, logic [3:0] op, logic [3:0] opd, logic [7:0] im,
                                logic lg, logic [11:0] pco, logic [11:0] ra);
        vec_t r;
        r.rst = rst; r.en = en; r.ld = ld; r.addr = addr; r.rdy = rdy;
        r.v = v; r.op = op; r.opd = opd; r.im = im; r.lg = lg; r.pco = pco; r.ra = ra;
        return r;
    endfunction

    function automatic logic [41:0] observed();
        return {out_valid, opcode, operand, imm, is_long, pc_out, rom_addr};
    endfunction

    task automatic check(input string name, input logic [41:0] act, input logic [41:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (valid,op,opd,imm,long,pc_out,rom_addr)",
                     name, act, exp);
        end
    endtask

    // Apply inputs at a falling edge, clock once, return at the next falling edge.
    task automatic step(input logic rst, input logic en, input logic ld, input logic [11:0] addr,
                        input logic rdy);
        reset = rst; enable = en; load_pc = ld; load_addr = addr; out_ready = rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Instruction length in bytes, from the opcode's long-marker bit.
    function automatic int ilen(logic [11:0] a);
        logic [3:0] op;
        op = rom[a][7:4];
        return op[3] ? 2 : 1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [11:0] m_pc, a1;
        logic        m_valid;
        int          m_cd;
        logic [41:0] exp;

        reset = 1'b1; enable = 1'b0; load_pc = 1'b0; load_addr = '0; out_ready = 1'b0;
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        rom[12'h000] = 8'h12;
        rom[12'h001] = 8'h9A;
        rom[12'h002] = 8'h55;
        rom[12'h003] = 8'h34;
        rom[12'hFFF] = 8'h8C;

        //            rst en ld addr    rdy  v  op    opd   imm    lg pc_out   rom_addr
        vecs.push_back(mk(1, 0, 0, 12'h000, 0, 0, 4'h0, 4'h0, 8'h00, 0, 12'h000, 12'h000));
        vecs.push_back(mk(0, 1, 0, 12'h000, 1, 0, 4'h0, 4'h0, 8'h00, 0, 12'h000, 12'h000));
        vecs.push_back(mk(0, 1, 0, 12'h000, 1, 1, 4'h1, 4'h2, 8'h00, 0, 12'h000, 12'h001));
        vecs.push_back(mk(0, 1, 0, 12'h000, 1, 0, 4'h1, 4'h2, 8'h00, 0, 12'h000, 12'h001));
        vecs.push_back(mk(0, 1, 0, 12'h000, 1, 0, 4'h9, 4'hA, 8'h00, 1, 12'h001, 12'h002));
        vecs.push_back(mk(0, 1, 0, 12'h000, 1, 1, 4'h9, 4'hA, 8'h55, 1, 12'h001, 12'h003));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 1, 0, 12'h000, 0, 1, 4'h9, 4'hA, 8'h55, 1, 12'h001, 12'h003));
        vecs.push_back(mk(0, 1, 0, 12'h000, 1, 0, 4'h9, 4'hA, 8'h55, 1, 12'h001, 12'h003));
        vecs.push_back(mk(0, 1, 0, 12'h000, 1, 1, 4'h3, 4'h4, 8'h00, 0, 12'h003, 12'h004));
        vecs.push_back(mk(0, 1, 1, 12'hFFF, 1, 0, 4'h3, 4'h4, 8'h00, 0, 12'h003, 12'hFFF));
        vecs.push_back(mk(0, 1, 0, 12'h000, 1, 0, 4'h8, 4'hC, 8'h00, 1, 12'hFFF, 12'h000));
        vecs.push_back(mk(0, 1, 0, 12'h000, 1, 1, 4'h8, 4'hC, 8'h12, 1, 12'hFFF, 12'h001));
        vecs.push_back(mk(0, 1, 0, 12'h000, 1, 0, 4'h8, 4'hC, 8'h12, 1, 12'hFFF, 12'h001));
        vecs.push_back(mk(0, 1, 0, 12'h000, 1, 0, 4'h9, 4'hA, 8'h00, 1, 12'h001, 12'h002));
        vecs.push_back(mk(1, 1, 1, 12'h123, 1, 0, 4'h0, 4'h0, 8'h00, 0, 12'h000, 12'h000));
        vecs.push_back(mk(0, 0, 0, 12'h000, 1, 0, 4'h0, 4'h0, 8'h00, 0, 12'h000, 12'h000));
        vecs.push_back(mk(0, 1, 0, 12'h000, 0, 0, 4'h0, 4'h0, 8'h00, 0, 12'h000, 12'h000));
        vecs.push_back(mk(0, 0, 0, 12'h000, 0, 1, 4'h1, 4'h2, 8'h00, 0, 12'h000, 12'h001));
        vecs.push_back(mk(0, 0, 0, 12'h000, 1, 0, 4'h1, 4'h2, 8'h00, 0, 12'h000, 12'h001));
        vecs.push_back(mk(0, 0, 0, 12'h000, 1, 0, 4'h1, 4'h2, 8'h00, 0, 12'h000, 12'h001));
        vecs.push_back(mk(0, 0, 1, 12'h002, 1, 0, 4'h1, 4'h2, 8'h00, 0, 12'h000, 12'h002));
        vecs.push_back(mk(0, 1, 0, 12'h000, 1, 0, 4'h1, 4'h2, 8'h00, 0, 12'h000, 12'h002));
        vecs.push_back(mk(0, 1, 0, 12'h000, 1, 1, 4'h5, 4'h5, 8'h00, 0, 12'h002, 12'h003));

        @(negedge clk);
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].ld, vecs[i].addr, vecs[i].rdy);
            check($sformatf("vec%0d", i), observed(),
                  {vecs[i].v, vecs[i].op, vecs[i].opd, vecs[i].im, vecs[i].lg, vecs[i].pco,
                   vecs[i].ra});
        end

        // Jump while fetching the first byte: the partial fetch at 003 is dropped.
        step(0, 1, 0, 12'h000, 1);
        check("jmp_accept", observed(), {1'b0, 4'h5, 4'h5, 8'h00, 1'b0, 12'h002, 12'h003});
        step(0, 1, 1, 12'h001, 1);
        check("jmp_in_fetch", observed(), {1'b0, 4'h5, 4'h5, 8'h00, 1'b0, 12'h002, 12'h001});
        step(0, 1, 0, 12'h000, 0);
        check("jmp_fetch1", observed(), {1'b0, 4'h9, 4'hA, 8'h00, 1'b1, 12'h001, 12'h002});
        step(0, 1, 0, 12'h000, 0);
        check("jmp_issue", observed(), {1'b1, 4'h9, 4'hA, 8'h55, 1'b1, 12'h001, 12'h003});

        // Randomized run against an instruction-level program model.
        for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom_range(0, 255));
        step(1, 0, 0, 12'h000, 0);
        reset = 1'b0; enable = 1'b1;
        m_pc    = 12'h000;
        m_valid = 1'b0;
        m_cd    = ilen(12'h000) + 1;
        for (int c = 0; c < 3000; c++) begin
            n_tests++;
            if (out_valid !== m_valid) begin
                n_fail++;
                $display("FAIL rnd_valid cycle %0d: got %b expected %b", c, out_valid, m_valid);
            end
            if (m_valid) begin
                a1  = m_pc + 12'd1;
                exp = {1'b1, rom[m_pc][7:4], rom[m_pc][3:0],
                       (ilen(m_pc) == 2) ? rom[a1] : 8'h00, ilen(m_pc) == 2, m_pc,
                       m_pc + 12'(ilen(m_pc))};
                check($sformatf("rnd_instr cycle %0d", c), observed(), exp);
            end
            load_pc   = ($urandom_range(0, 19) == 0);
            load_addr = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom_range(0, 4095));
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            if (load_pc) begin
                m_pc    = load_addr;
                m_valid = 1'b0;
                m_cd    = ilen(m_pc);
            end else if (m_valid && out_ready) begin
                m_pc    = m_pc + 12'(ilen(m_pc));
                m_valid = 1'b0;
                m_cd    = ilen(m_pc);
            end else if (m_cd > 0) begin
                m_cd--;
                if (m_cd == 0) m_valid = 1'b1;
            end
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
